// File: rtl/seq_fetch_pkg.sv
// Shared definitions for the Seq instruction-fetch stage: FSM encoding,
// default widths and the Seq opcode constants used to build programs.
package seq_fetch_pkg;

  localparam int AW_DEF  = 8;
  localparam int IW_DEF  = 20;
  localparam int CW_DEF  = 16;
  localparam int OP_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // Seq opcodes live in the top OP_W bits of an instruction word.
  localparam logic [OP_W-1:0] Seq_NO = 3'd0;
  localparam logic [OP_W-1:0] Seq_CI = 3'd1;
  localparam logic [OP_W-1:0] Seq_CR = 3'd2;
  localparam logic [OP_W-1:0] Seq_JI = 3'd3;
  localparam logic [OP_W-1:0] Seq_JR = 3'd4;
  localparam logic [OP_W-1:0] Seq_JZ = 3'd5;
  localparam logic [OP_W-1:0] Seq_JN = 3'd6;

  // Builds a word with an opcode and an 8-bit immediate, middle bits zero.
  function automatic logic [IW_DEF-1:0] mk_inst(input logic [OP_W-1:0] op,
                                                input logic [7:0] imm);
    return {op, 9'd0, imm};
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: one write port, one read port, registered read data.
// Contents are deliberately not reset; the read register only moves when
// ren is high so the last fetched word stays put between fetches.
module seq_prog_mem
  import seq_fetch_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clock,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [1 << AW];

  // Synchronous write and 1-cycle-latency read.
  always_ff @(posedge clock) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/seq_fetch.sv
// Instruction-fetch stage feeding the Seq sequencer. Each instruction takes
// two cycles: FETCH reads RAM at `next`, ISSUE presents it with inst_en.
// inst_en is a one-cycle valid strobe with no back-pressure: Seq must take
// the word in the cycle inst_en is high, and updates `next` on that edge.
module seq_fetch
  import seq_fetch_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_wen,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          run,
  input  logic          step,
  input  logic          halt,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] next,
  output logic [IW-1:0] inst,
  output logic          inst_en,
  output logic          running,
  output logic          bp_hit,
  output logic          prog_err,
  output logic [CW-1:0] icount,
  output logic [1:0]    fsm_state
);

  state_t        state_q, state_d;
  logic          single_q;
  logic          first_q;
  logic          halt_q;
  logic          loaded_q;
  logic          bp_hit_q;
  logic          prog_err_q;
  logic [CW-1:0] icount_q;
  logic [IW-1:0] ram_rdata;
  logic          start;
  logic          bp_stop;

  assign start   = (state_q == ST_IDLE) && (run || step);
  // The first FETCH after leaving IDLE ignores the breakpoint so a stopped
  // program can resume from the breakpoint address.
  assign bp_stop = (state_q == ST_FETCH) && bp_en && (next == bp_addr) && !first_q;

  seq_prog_mem #(.AW(AW), .IW(IW)) u_mem (
    .clock (clock),
    .wen   (prog_wen && (state_q == ST_IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .ren   (state_q == ST_FETCH),
    .raddr (next),
    .rdata (ram_rdata)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run || step) state_d = ST_FETCH;
      ST_FETCH: state_d = bp_stop ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: state_d = (single_q || halt_q || halt) ? ST_IDLE : ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register plus control flags and the issue counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      single_q   <= 1'b0;
      first_q    <= 1'b0;
      halt_q     <= 1'b0;
      loaded_q   <= 1'b0;
      bp_hit_q   <= 1'b0;
      prog_err_q <= 1'b0;
      icount_q   <= '0;
    end else begin
      state_q    <= state_d;
      prog_err_q <= prog_wen && (state_q != ST_IDLE);
      if (start) begin
        single_q <= !run;
        first_q  <= 1'b1;
        bp_hit_q <= 1'b0;
      end
      if (state_q == ST_FETCH) begin
        first_q  <= 1'b0;
        loaded_q <= 1'b1;
      end
      if (bp_stop) bp_hit_q <= 1'b1;
      if (state_q == ST_IDLE) halt_q <= 1'b0;
      else if (halt)          halt_q <= 1'b1;
      if (state_q == ST_ISSUE) icount_q <= icount_q + CW'(1);
    end
  end

  // Until the first fetch after reset the RAM register is meaningless; show 0.
  assign inst      = loaded_q ? ram_rdata : '0;
  assign inst_en   = (state_q == ST_ISSUE);
  assign running   = (state_q != ST_IDLE);
  assign bp_hit    = bp_hit_q;
  assign prog_err  = prog_err_q;
  assign icount    = icount_q;
  assign fsm_state = state_q;

endmodule

// File: doc/seq_fetch.md
Name: seq_fetch

Overview:
- Instruction-fetch stage directly upstream of the Seq sequencer.
- Holds the sequencer program in a 256x20 synchronous RAM, loaded through a write port while stopped.
- On every fetch, reads the word addressed by Seq's `next` and presents it on `inst`/`inst_en`.
- Provides run, single-step, halt and one address breakpoint for bring-up and debug.

Parameters:
- AW, 8: program address width; must equal the width of Seq `next`.
- IW, 20: instruction width; must equal the width of Seq `inst`.
- CW, 16: width of the issued-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- prog_wen  in  1  program write strobe; honoured only in IDLE.
- prog_addr  in  AW  program write address.
- prog_data  in  IW  program write data.
- run  in  1  pulse: start free-running fetch.
- step  in  1  pulse: fetch and issue exactly one instruction.
- halt  in  1  pulse: stop after the current instruction.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  AW  breakpoint address.
- next  in  AW  program counter from Seq.
- inst  out  IW  instruction to Seq.
- inst_en  out  1  instruction valid, high for exactly one cycle per issued instruction.
- running  out  1  high in FETCH or ISSUE.
- bp_hit  out  1  sticky; set when a breakpoint stops execution.
- prog_err  out  1  one-cycle pulse when `prog_wen` arrives outside IDLE.
- icount  out  CW  count of issued instructions.

Behaviour:
- Clock and reset: one clock domain; reset synchronous and active-high.
- Reset values: state=IDLE, inst=0, inst_en=0, running=0, bp_hit=0, prog_err=0, icount=0. Program RAM contents are not reset.
- Reset mid-operation: IDLE on the same edge; an in-flight ISSUE is dropped (`inst_en`=0 after the edge).
- FSM states:
  - IDLE
  - FETCH: RAM read at `next`, result registered into `inst`.
  - ISSUE: `inst_en`=1.
- IDLE transitions:
  - `run` -> FETCH with single=0.
  - `step` -> FETCH with single=1.
  - `run` and `step` together: `run` wins.
  - `run` or `step` clears `bp_hit`.
- FETCH -> ISSUE unconditionally, except the breakpoint case below.
- Breakpoint: in FETCH, if `bp_en` and `next==bp_addr` and this is not the first FETCH since leaving IDLE -> IDLE, `bp_hit`=1, no issue. The first-FETCH exemption lets the design resume from a breakpoint.
- ISSUE exit:
  - If single, or `halt` seen since the last FETCH -> IDLE.
  - Otherwise -> FETCH.
- Halt: a `halt` pulse in FETCH or ISSUE is latched. The current instruction always completes its ISSUE before stopping. `halt` in IDLE is ignored.
- Throughput and latency: 2 cycles per instruction. `next` is sampled in FETCH, after Seq updated it on the ISSUE edge. `inst` is valid from the FETCH->ISSUE edge and held stable until the next FETCH completes.
- `inst_en` is 0 in every state except ISSUE.
- `icount` increments by 1 on each ISSUE cycle and wraps modulo 2^CW.
- Program write: in IDLE, `prog_wen` writes `prog_data` to RAM[`prog_addr`] on the edge. Outside IDLE the write is dropped and `prog_err` pulses for 1 cycle. Because writes only happen in IDLE, read and write never collide.
- Address wrap: `next`=0xFF is read normally. Address wrap is Seq's responsibility.
- Opcodes are never decoded here. Illegal words are passed through unchanged.

Decomposition:
- Shared package: FSM state encoding (IDLE/FETCH/ISSUE), AW/IW defaults, and the Seq opcode constants (Seq_NO, Seq_CI, Seq_CR, Seq_JI, Seq_JR, Seq_JZ, Seq_JN) used by benches to build programs.
- One sub-module, `seq_prog_mem`: single-write, single-read synchronous RAM with 1-cycle read latency and no reset.

Test Plan:
- Load and step: write RAM[0]={Seq_CI,x,3'b010,4'h1,8'hAA}, `next`=0, `step` -> `inst_en` high exactly one cycle, 2 cycles after `step`, `inst`=that word; then IDLE, `icount`=1.
- Free run: program RAM[0..3]={JI 0x02, NO, NO, JI 0x00} with Seq attached, `run` -> `inst_en` toggles 1 every 2nd cycle; `next` sequence 00,02,03,00; `icount` increments per issue.
- Halt: `halt` pulsed during FETCH -> that instruction still issues (one more `inst_en`), then `running`=0 and `inst_en` stays 0.
- Breakpoint: `bp_en`=1, `bp_addr`=0x03, `run` from 0 -> stop with `bp_hit`=1 and the word at 0x03 not issued; second `run` -> 0x03 issues, `bp_hit` clears.
- Write protection: `prog_wen` with addr 0x10, data 0xAEF0F while running -> `prog_err` one-cycle pulse; after halt, RAM[0x10] unchanged (read back via step with `next`=0x10).
- Reset mid-run: assert `reset` during ISSUE for 2 cycles -> `inst_en`=0, `icount`=0, IDLE on the first reset edge; after release, `run` with `next`=0 resumes from RAM[0].
